// File: rtl/jk_bank_ctrl.sv
// Round-robin sequencer for a bank of JK flip-flops: grants one requester at a time,
// pulses that bit's j/k for one clock, reads the bit back and acknowledges with pass/fail.
module jk_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [IDXW*NREQ-1:0]   idx,
    output logic [WIDTH-1:0]       j,
    output logic [WIDTH-1:0]       k,
    input  logic [WIDTH-1:0]       q_fb,
    output logic [NREQ-1:0]        gnt,
    output logic                   ack,
    output logic                   err,
    output logic                   busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [PTRW-1:0]  r_ptr;
    logic [PTRW-1:0]  r_winner;
    logic [IDXW-1:0]  r_idx;
    logic             r_expected;
    logic             r_bad;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [NREQ-1:0]  r_gnt;
    logic             r_ack;
    logic             r_err;
    logic             r_busy;

    logic             w_found;
    logic [PTRW-1:0]  w_winner;
    logic [1:0]       w_winOp;
    logic [IDXW-1:0]  w_winIdx;
    logic [WIDTH-1:0] w_sel;
    logic             w_curQ;
    logic             w_winBad;
    logic             w_expected;
    logic             w_fbBit;

    // Round-robin search starting at the pointer; first hit wins.
    always_comb begin
        int cand;
        cand     = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(r_ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!w_found && req[cand]) begin
                w_found  = 1'b1;
                w_winner = PTRW'(cand);
            end
        end
    end

    always_comb begin
        w_winOp  = 2'b00;
        w_winIdx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (w_winner == PTRW'(r)) begin
                w_winOp  = op[2*r +: 2];
                w_winIdx = idx[IDXW*r +: IDXW];
            end
        end
    end

    // Index decode doubles as range check: an index past WIDTH selects nothing.
    always_comb begin
        w_sel    = '0;
        w_curQ   = 1'b0;
        w_winBad = 1'b1;
        w_fbBit  = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (w_winIdx == IDXW'(b)) begin
                w_sel[b] = 1'b1;
                w_curQ   = q_fb[b];
                w_winBad = 1'b0;
            end
            if (r_idx == IDXW'(b)) begin
                w_fbBit = q_fb[b];
            end
        end
    end

    always_comb begin
        case (w_winOp)
            2'b00:   w_expected = w_curQ;
            2'b01:   w_expected = 1'b0;
            2'b10:   w_expected = 1'b1;
            default: w_expected = ~w_curQ;
        endcase
    end

    // j/k are loaded on entry to ISSUE so they are live for exactly that one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_idx      <= '0;
            r_expected <= 1'b0;
            r_bad      <= 1'b0;
            r_j        <= '0;
            r_k        <= '0;
            r_gnt      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_j   <= '0;
            r_k   <= '0;
            r_gnt <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_ISSUE;
                        r_winner   <= w_winner;
                        r_idx      <= w_winIdx;
                        r_expected <= w_expected;
                        r_bad      <= w_winBad;
                        r_j        <= w_winOp[1] ? w_sel : '0;
                        r_k        <= w_winOp[0] ? w_sel : '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_state <= S_DONE;
                    r_err   <= r_bad ? 1'b1 : (w_fbBit != r_expected);
                    r_ack   <= 1'b1;
                    r_gnt   <= NREQ'(1) << r_winner;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_winner == PTRW'(NREQ - 1)) ? '0 : r_winner + PTRW'(1);
                end
            endcase
        end
    end

    assign j    = r_j;
    assign k    = r_k;
    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign err  = r_err;
    assign busy = r_busy;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl with a behavioural JK bank model on j/k/q_fb.
module tb_jk_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [15:0] idx;
    logic [7:0]  j;
    logic [7:0]  k;
    logic [7:0]  q_fb;
    logic [3:0]  gnt;
    logic        ack;
    logic        err;
    logic        busy;

    logic [7:0]  qBank = 8'h00;
    logic [7:0]  stuckMask;
    int          cycleCount = 0;
    int          lastAckCycle;
    int          firstAckCycle;
    int          testsRun = 0;
    int          testsFailed = 0;

    jk_bank_ctrl #(.NREQ(4), .WIDTH(8), .IDXW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op    (op),
        .idx   (idx),
        .j     (j),
        .k     (k),
        .q_fb  (q_fb),
        .gnt   (gnt),
        .ack   (ack),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        qBank      <= (j & ~qBank) | (~k & qBank);
    end

    assign q_fb = qBank & ~stuckMask;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [7:0] opV, input logic [15:0] idxV);
        req = reqV;
        op  = opV;
        idx = idxV;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        req   = 4'b0000;
        waitEdge();
        waitEdge();
        rst_n = 1'b1;
    endtask

    // One full operation: sample edge, ISSUE, CHECK, DONE, back to IDLE.
    task automatic runOp(input string tag, input logic [3:0] reqV, input logic [7:0] opV,
                         input logic [15:0] idxV, input logic [7:0] expJ, input logic [7:0] expK,
                         input logic [3:0] expGnt, input logic expErr, input logic [3:0] reqAfter);
        applyStimulus(reqV, opV, idxV);
        waitEdge();
        checkOutput({tag, " issue j"}, {24'h0, j}, {24'h0, expJ});
        checkOutput({tag, " issue k"}, {24'h0, k}, {24'h0, expK});
        checkOutput({tag, " issue busy"}, {31'h0, busy}, 32'h1);
        checkOutput({tag, " issue ack"}, {31'h0, ack}, 32'h0);
        waitEdge();
        checkOutput({tag, " check jk"}, {16'h0, j, k}, 32'h0);
        waitEdge();
        checkOutput({tag, " ack"}, {31'h0, ack}, 32'h1);
        checkOutput({tag, " gnt"}, {28'h0, gnt}, {28'h0, expGnt});
        checkOutput({tag, " err"}, {31'h0, err}, {31'h0, expErr});
        lastAckCycle = cycleCount;
        req = reqAfter;
        waitEdge();
        checkOutput({tag, " idle ack/gnt"}, {27'h0, ack, gnt}, 32'h0);
        checkOutput({tag, " idle busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stuckMask = 8'h00;
        op        = 8'h00;
        idx       = 16'h0000;
        resetDut();
        checkOutput("reset outputs", {j, k, 4'h0, gnt, 5'h0, ack, err, busy}, 32'h0);

        // Set bit 3 from requester 0 on an empty bank.
        runOp("set3", 4'b0001, 8'h02, 16'h0003, 8'h08, 8'h00, 4'b0001, 1'b0, 4'b0000);
        checkOutput("set3 bank", {24'h0, qBank}, 32'h08);

        // Toggle bit 7 twice from requester 2.
        resetDut();
        runOp("tog7a", 4'b0100, 8'h30, 16'h0700, 8'h80, 8'h80, 4'b0100, 1'b0, 4'b0000);
        checkOutput("tog7a bank", {24'h0, qBank}, 32'h88);
        firstAckCycle = lastAckCycle;
        runOp("tog7b", 4'b0100, 8'h30, 16'h0700, 8'h80, 8'h80, 4'b0100, 1'b0, 4'b0000);
        checkOutput("tog7b bank", {24'h0, qBank}, 32'h08);
        checkOutput("tog7 ack spacing", lastAckCycle - firstAckCycle, 32'd4);

        // All four requesting hold continuously: strict rotation from pointer 0.
        resetDut();
        runOp("rr0", 4'b1111, 8'h00, 16'h3210, 8'h00, 8'h00, 4'b0001, 1'b0, 4'b1111);
        runOp("rr1", 4'b1111, 8'h00, 16'h3210, 8'h00, 8'h00, 4'b0010, 1'b0, 4'b1111);
        runOp("rr2", 4'b1111, 8'h00, 16'h3210, 8'h00, 8'h00, 4'b0100, 1'b0, 4'b1111);
        runOp("rr3", 4'b1111, 8'h00, 16'h3210, 8'h00, 8'h00, 4'b1000, 1'b0, 4'b1111);
        runOp("rr4", 4'b1111, 8'h00, 16'h3210, 8'h00, 8'h00, 4'b0001, 1'b0, 4'b0000);
        waitEdge();
        checkOutput("rr released busy", {31'h0, busy}, 32'h0);
        checkOutput("rr bank", {24'h0, qBank}, 32'h08);

        // Out-of-range index from requester 1.
        resetDut();
        runOp("badidx", 4'b0010, 8'h08, 16'h0090, 8'h00, 8'h00, 4'b0010, 1'b1, 4'b0000);
        checkOutput("badidx bank", {24'h0, qBank}, 32'h08);

        // Readback of bit 2 stuck at 0 while setting it.
        stuckMask = 8'h04;
        runOp("stuck2", 4'b0001, 8'h02, 16'h0002, 8'h04, 8'h00, 4'b0001, 1'b1, 4'b0000);
        stuckMask = 8'h00;
        checkOutput("stuck2 bank", {24'h0, qBank}, 32'h0C);

        // Reset during ISSUE aborts the operation and rewinds the pointer.
        resetDut();
        applyStimulus(4'b0001, 8'h02, 16'h0000);
        waitEdge();
        checkOutput("abort issue j", {24'h0, j}, 32'h01);
        rst_n = 1'b0;
        req   = 4'b0000;
        waitEdge();
        checkOutput("abort jk", {16'h0, j, k}, 32'h0);
        checkOutput("abort busy", {31'h0, busy}, 32'h0);
        checkOutput("abort ack", {31'h0, ack}, 32'h0);
        waitEdge();
        checkOutput("abort no gnt", {27'h0, ack, gnt}, 32'h0);
        rst_n = 1'b1;
        runOp("post0", 4'b1001, 8'h00, 16'h0000, 8'h00, 8'h00, 4'b0001, 1'b0, 4'b1000);
        runOp("post3", 4'b1000, 8'h00, 16'h0000, 8'h00, 8'h00, 4'b1000, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
